// File: rtl/cevero_dvfs_pkg.sv
// Shared constants, types and step helpers for the CEVERO error-driven DVFS controller.
package cevero_dvfs_pkg;

  localparam int DEF_WINDOW_CYCLES = 64;
  localparam int DEF_ERR_THRESHOLD = 4;
  localparam int DEF_RELAX_CYCLES  = 1024;
  localparam int DEF_V_MAX         = 7;
  localparam int DEF_F_STEP        = 10;
  localparam int DEF_F_MIN         = 50;

  localparam int ERR_CNT_W = 8;
  localparam int V_W       = 3;
  localparam int F_W       = 32;

  typedef logic [V_W-1:0]       volt_t;
  typedef logic [F_W-1:0]       freq_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_ESCALATE,
    ACT_RELAX
  } dvfs_act_e;

  // One voltage code toward the target; unchanged once it is reached.
  function automatic volt_t volt_toward(volt_t cur, volt_t tgt);
    volt_t res;
    res = cur;
    if (cur > tgt)      res = cur - V_W'(1);
    else if (cur < tgt) res = cur + V_W'(1);
    return res;
  endfunction

  // One frequency step toward the target, landing exactly on it when closer than a step.
  function automatic freq_t freq_toward(freq_t cur, freq_t tgt, freq_t step);
    freq_t res;
    res = cur;
    if (cur > tgt)      res = (cur - tgt >= step) ? cur - step : tgt;
    else if (cur < tgt) res = (tgt - cur >= step) ? cur + step : tgt;
    return res;
  endfunction

endpackage

// File: rtl/cevero_dvfs_if.sv
// Error input, default settings and commanded voltage/frequency of the DVFS controller.
interface cevero_dvfs_if
  import cevero_dvfs_pkg::*;
();

  logic     error_i;
  volt_t    def_voltage_i;
  freq_t    def_freq_i;
  volt_t    set_voltage_o;
  freq_t    set_freq_o;
  err_cnt_t err_count_o;

  modport slave (
    input  error_i, def_voltage_i, def_freq_i,
    output set_voltage_o, set_freq_o, err_count_o
  );

  modport master (
    output error_i, def_voltage_i, def_freq_i,
    input  set_voltage_o, set_freq_o, err_count_o
  );

endinterface

// File: rtl/dvfs_err_monitor.sv
// Counts error cycles inside a free-running observation window and flags escalation.
module dvfs_err_monitor
  import cevero_dvfs_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int ERR_THRESHOLD = DEF_ERR_THRESHOLD
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     i_error,
  output logic     o_escalate,
  output err_cnt_t o_err_count
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  logic [WIN_W-1:0]   r_win_cnt;
  err_cnt_t           r_err_cnt;
  logic [ERR_CNT_W:0] w_err_inc;
  err_cnt_t           w_err_sat;
  logic               w_wrap;
  logic               w_escalate;

  // One extra bit so the threshold compare still works when the counter is saturated.
  assign w_err_inc  = {1'b0, r_err_cnt} + (ERR_CNT_W+1)'(1);
  assign w_err_sat  = (&r_err_cnt) ? r_err_cnt : w_err_inc[ERR_CNT_W-1:0];
  assign w_wrap     = (r_win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  assign w_escalate = i_error && (w_err_inc >= (ERR_CNT_W+1)'(ERR_THRESHOLD));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_escalate) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_win_cnt <= w_wrap ? '0 : r_win_cnt + WIN_W'(1);
      if (w_wrap)       r_err_cnt <= ERR_CNT_W'(i_error);
      else if (i_error) r_err_cnt <= w_err_sat;
    end
  end

  assign o_escalate  = w_escalate;
  assign o_err_count = r_err_cnt;

endmodule

// File: rtl/cevero_dvfs.sv
// Error-driven DVFS controller: escalates voltage/frequency on error bursts, relaxes after quiet time.
module cevero_dvfs
  import cevero_dvfs_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int ERR_THRESHOLD = DEF_ERR_THRESHOLD,
  parameter int RELAX_CYCLES  = DEF_RELAX_CYCLES,
  parameter int V_MAX         = DEF_V_MAX,
  parameter int F_STEP        = DEF_F_STEP,
  parameter int F_MIN         = DEF_F_MIN
) (
  input  logic          clk_i,
  input  logic          rst_i,
  cevero_dvfs_if.slave  bus
);

  localparam int QUIET_W = $clog2(RELAX_CYCLES);

  logic [QUIET_W-1:0] r_quiet;
  volt_t              r_voltage;
  freq_t              r_freq;
  volt_t              w_v_next;
  freq_t              w_f_next;
  logic               w_escalate;
  logic               w_relax;
  err_cnt_t           w_err_count;
  dvfs_act_e          w_act;

  dvfs_err_monitor #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .ERR_THRESHOLD (ERR_THRESHOLD)
  ) u_err_monitor (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_error     (bus.error_i),
    .o_escalate  (w_escalate),
    .o_err_count (w_err_count)
  );

  assign w_relax = !bus.error_i && (r_quiet == QUIET_W'(RELAX_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_act    = ACT_HOLD;
    w_v_next = r_voltage;
    w_f_next = r_freq;
    if (w_escalate)   w_act = ACT_ESCALATE;
    else if (w_relax) w_act = ACT_RELAX;
    unique case (w_act)
      ACT_ESCALATE: begin
        w_v_next = (r_voltage >= V_W'(V_MAX)) ? V_W'(V_MAX) : r_voltage + V_W'(1);
        // Compare before subtracting so the frequency can never wrap below zero.
        w_f_next = (r_freq >= F_W'(F_MIN + F_STEP)) ? r_freq - F_W'(F_STEP) : F_W'(F_MIN);
      end
      ACT_RELAX: begin
        w_v_next = volt_toward(r_voltage, bus.def_voltage_i);
        w_f_next = freq_toward(r_freq, bus.def_freq_i, F_W'(F_STEP));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_voltage <= bus.def_voltage_i;
      r_freq    <= bus.def_freq_i;
      r_quiet   <= '0;
    end else begin
      r_voltage <= w_v_next;
      r_freq    <= w_f_next;
      r_quiet   <= (bus.error_i || w_relax) ? '0 : r_quiet + QUIET_W'(1);
    end
  end

  assign bus.set_voltage_o = r_voltage;
  assign bus.set_freq_o    = r_freq;
  assign bus.err_count_o   = w_err_count;

endmodule

// File: tb/tb_cevero_dvfs.sv
// Directed bench for cevero_dvfs with a cycle-level behavioural model checked every cycle.
module tb_cevero_dvfs;

  localparam int WINDOW = 64;
  localparam int THR    = 4;
  localparam int RELAX  = 1024;
  localparam int VMAX   = 7;
  localparam int FSTEP  = 10;
  localparam int FMIN   = 50;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  cevero_dvfs_if bus();

  cevero_dvfs u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Model state: plain integers following the behavioural rules.
  bit m_valid = 1'b0;
  int m_v, m_f, m_errs, m_win, m_quiet;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit err, input bit rst);
    bit esc;
    int diff;
    if (rst) begin
      m_v = int'(bus.def_voltage_i);
      m_f = int'(bus.def_freq_i);
      m_errs = 0; m_win = 0; m_quiet = 0;
      m_valid = 1'b1;
      return;
    end
    esc = err && (m_errs + 1 >= THR);
    if (esc) begin
      m_v = (m_v + 1 > VMAX) ? VMAX : m_v + 1;
      m_f = (m_f - FSTEP < FMIN) ? FMIN : m_f - FSTEP;
      m_errs = 0;
      m_win  = 0;
    end else if (m_win == WINDOW - 1) begin
      m_win  = 0;
      m_errs = err ? 1 : 0;
    end else begin
      m_win++;
      if (err) m_errs = (m_errs == 255) ? 255 : m_errs + 1;
    end
    if (err) m_quiet = 0;
    else if (m_quiet == RELAX - 1) begin
      m_quiet = 0;
      if (m_v < int'(bus.def_voltage_i)) m_v++;
      else if (m_v > int'(bus.def_voltage_i)) m_v--;
      diff = int'(bus.def_freq_i) - m_f;
      if (diff >= FSTEP)       m_f += FSTEP;
      else if (diff <= -FSTEP) m_f -= FSTEP;
      else                     m_f = int'(bus.def_freq_i);
    end else m_quiet++;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the following negedge.
  task automatic step(input bit err, input bit rst);
    bus.error_i = err;
    rst_i = rst;
    @(posedge clk_i);
    model_update(err, rst);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (m_valid) begin
      check("model_voltage", 32'(bus.set_voltage_o), 32'(m_v));
      check("model_freq",    bus.set_freq_o,         32'(m_f));
      check("model_errcnt",  32'(bus.err_count_o),   32'(m_errs));
    end
  end

  initial begin
    bus.error_i       = 1'b0;
    bus.def_voltage_i = 3'd5;
    bus.def_freq_i    = 32'd150;
    @(negedge clk_i);

    // Reset and long quiet period at the defaults.
    step(1'b0, 1'b1);
    check("rst_voltage", 32'(bus.set_voltage_o), 32'd5);
    check("rst_freq",    bus.set_freq_o,         32'd150);
    check("rst_errcnt",  32'(bus.err_count_o),   32'd0);
    idle(1000);
    check("quiet_voltage", 32'(bus.set_voltage_o), 32'd5);
    check("quiet_freq",    bus.set_freq_o,         32'd150);

    // Two errors, then pulses every 7 cycles: fourth error escalates.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b0);
    check("pre_esc_freq", bus.set_freq_o, 32'd150);
    idle(6);
    step(1'b1, 1'b0);
    check("esc1_voltage", 32'(bus.set_voltage_o), 32'd6);
    check("esc1_freq",    bus.set_freq_o,         32'd140);
    check("esc1_errcnt",  32'(bus.err_count_o),   32'd0);

    // Relax exactly RELAX cycles after the last error, then no further change.
    idle(RELAX - 1);
    check("pre_relax_freq", bus.set_freq_o, 32'd140);
    idle(1);
    check("relax_voltage", 32'(bus.set_voltage_o), 32'd5);
    check("relax_freq",    bus.set_freq_o,         32'd150);
    idle(1500);
    check("relax_hold_freq", bus.set_freq_o, 32'd150);

    // Alternating pulses: escalate on the 4th, counter 1 after the 5th; later 4 more pulses.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) check("alt_esc_freq", bus.set_freq_o, 32'd140);
      if (i == 4) check("alt_errcnt",   32'(bus.err_count_o), 32'd1);
      step(1'b0, 1'b0);
    end
    idle(99);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      if (i < 3) step(1'b0, 1'b0);
    end
    check("alt2_voltage", 32'(bus.set_voltage_o), 32'd7);
    check("alt2_freq",    bus.set_freq_o,         32'd130);

    // Saturation at V_MAX and F_MIN with defaults 7/60.
    bus.def_voltage_i = 3'd7;
    bus.def_freq_i    = 32'd60;
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("sat_voltage", 32'(bus.set_voltage_o), 32'd7);
      check("sat_freq",    bus.set_freq_o,         32'd50);
      check("sat_errcnt",  32'(bus.err_count_o),   32'd0);
    end

    // Window wraps after three errors; then reset in the escalating cycle.
    bus.def_voltage_i = 3'd5;
    bus.def_freq_i    = 32'd150;
    step(1'b0, 1'b1);
    idle(WINDOW - 4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("win_pre_errcnt", 32'(bus.err_count_o), 32'd3);
    step(1'b0, 1'b0);
    check("wrap_errcnt", 32'(bus.err_count_o), 32'd0);
    step(1'b1, 1'b0);
    check("wrap_noesc_freq", bus.set_freq_o,       32'd150);
    check("wrap_errcnt1",    32'(bus.err_count_o), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("esc_again_freq", bus.set_freq_o, 32'd140);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_voltage", 32'(bus.set_voltage_o), 32'd5);
    check("midrst_freq",    bus.set_freq_o,         32'd150);
    check("midrst_errcnt",  32'(bus.err_count_o),   32'd0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
